// File: rtl/ow_temp_responder.sv
// ow_temp_responder: one-wire DS18B20 emulator (presence, Skip ROM, Convert T, Read Scratchpad with CRC8)
module ow_temp_responder #(
  parameter int CLK_PER_US = 48,
  parameter int RST_MIN_US = 400,
  parameter int PD_WAIT_US = 30,
  parameter int PD_LEN_US  = 120,
  parameter int SAMPLE_US  = 30,
  parameter int HOLD_US    = 30
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_owr,
  output logic        o_owr,
  input  logic [15:0] i_temp,
  output logic        o_convert,
  output logic [7:0]  o_cmd,
  output logic        o_cmd_valid,
  output logic        o_active
);
  typedef enum logic [2:0] {S_IDLE, S_PD_WAIT, S_PD, S_ROM, S_FUNC, S_CONV, S_TX} state_t;
  localparam int PW = CLK_PER_US > 1 ? $clog2(CLK_PER_US) : 1;
  localparam int LW = $clog2(RST_MIN_US + 1);
  localparam int TW = 10;
  localparam logic [PW-1:0] P_TOP = PW'(CLK_PER_US - 1);
  localparam logic [LW-1:0] L_MAX = LW'(RST_MIN_US);
  localparam logic [TW-1:0] T_PDW = TW'(PD_WAIT_US - 1);
  localparam logic [TW-1:0] T_PDL = TW'(PD_LEN_US - 1);
  localparam logic [TW-1:0] T_SMP = TW'(SAMPLE_US - 1);
  localparam logic [TW-1:0] T_HLD = TW'(HOLD_US - 1);
  state_t state, state_n;
  logic s1, s2, prev, tick, fall_ok, rst_det, clr, tx_bit, fb;
  logic pend, pend_n, owr_n, act_n, cmdv_n, conv_n;
  logic [PW-1:0] pre;
  logic [TW-1:0] tus;
  logic [LW-1:0] lowc;
  logic [1:0] guard;
  logic [2:0] bitc, bitc_n;
  logic [3:0] byt, byt_n;
  logic [7:0] sr, sr_n, crc, crc_n, cmd_n, nbyte, sp_byte;
  logic [15:0] temp, temp_n;
  assign tick = pre == P_TOP;
  assign fall_ok = prev & ~s2 & ~o_owr & (guard == 2'd0);
  assign rst_det = ~prev & s2 & (lowc == L_MAX);
  assign nbyte = {s2, sr[7:1]};
  assign tx_bit = byt == 4'd8 ? crc[bitc] : byt == 4'd9 ? 1'b1 : sp_byte[bitc];
  assign fb = crc[0] ^ tx_bit;
  always_comb begin
    sp_byte = 8'hFF;
    case (byt)
      4'd0: sp_byte = temp[7:0];
      4'd1: sp_byte = temp[15:8];
      4'd2: sp_byte = 8'h4B;
      4'd3: sp_byte = 8'h46;
      4'd4: sp_byte = 8'h7F;
      4'd5: sp_byte = 8'hFF;
      4'd6: sp_byte = 8'h0C;
      4'd7: sp_byte = 8'h10;
      default: sp_byte = 8'hFF;
    endcase
  end
  always_comb begin
    state_n = state;
    owr_n = o_owr;
    act_n = o_active;
    cmd_n = o_cmd;
    cmdv_n = 1'b0;
    conv_n = 1'b0;
    temp_n = temp;
    sr_n = sr;
    bitc_n = bitc;
    byt_n = byt;
    crc_n = crc;
    pend_n = pend;
    clr = 1'b0;
    case (state)
      S_PD_WAIT: if (tick && tus == T_PDW) begin
        state_n = S_PD;
        owr_n = 1'b1;
        clr = 1'b1;
      end
      S_PD: if (tick && tus == T_PDL) begin
        state_n = S_ROM;
        owr_n = 1'b0;
        act_n = 1'b1;
      end
      S_ROM, S_FUNC: begin
        if (fall_ok) pend_n = 1'b1;
        if (pend && tick && tus == T_SMP) begin
          pend_n = 1'b0;
          sr_n = nbyte;
          bitc_n = bitc + 3'd1;
          if (bitc == 3'd7 && state == S_ROM) begin
            state_n = nbyte == 8'hCC ? S_FUNC : S_IDLE;
            act_n = nbyte == 8'hCC;
          end else if (bitc == 3'd7) begin
            cmd_n = nbyte;
            cmdv_n = 1'b1;
            conv_n = nbyte == 8'h44;
            temp_n = nbyte == 8'h44 ? i_temp : temp;
            crc_n = 8'h00;
            byt_n = 4'd0;
            state_n = nbyte == 8'h44 ? S_CONV : nbyte == 8'hBE ? S_TX : S_IDLE;
            act_n = nbyte == 8'h44 || nbyte == 8'hBE;
          end
        end
      end
      S_TX: if (fall_ok) begin
        owr_n = ~tx_bit;
        crc_n = byt < 4'd8 ? {fb, crc[7:1]} ^ {4'b0, fb, fb, 2'b0} : crc;
        bitc_n = bitc + 3'd1;
        byt_n = (bitc == 3'd7 && byt != 4'd9) ? byt + 4'd1 : byt;
      end else if (o_owr && tick && tus == T_HLD) owr_n = 1'b0;
      default: ;
    endcase
    if (rst_det) begin
      state_n = S_PD_WAIT;
      owr_n = 1'b0;
      act_n = 1'b0;
      bitc_n = 3'd0;
      byt_n = 4'd0;
      pend_n = 1'b0;
      clr = 1'b1;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      {s1, s2, prev} <= 3'b111;
      pre <= '0;
      tus <= '0;
      lowc <= '0;
      guard <= 2'd0;
      state <= S_IDLE;
      o_owr <= 1'b0;
      o_active <= 1'b0;
      o_cmd <= 8'h00;
      o_cmd_valid <= 1'b0;
      o_convert <= 1'b0;
      temp <= 16'h0550;
      sr <= 8'h00;
      bitc <= 3'd0;
      byt <= 4'd0;
      crc <= 8'h00;
      pend <= 1'b0;
    end else begin
      s1 <= i_owr;
      s2 <= s1;
      prev <= s2;
      pre <= (clr || fall_ok || tick) ? '0 : pre + PW'(1);
      tus <= (clr || fall_ok) ? '0 : tick ? tus + TW'(1) : tus;
      lowc <= s2 ? '0 : (tick && lowc != L_MAX) ? lowc + LW'(1) : lowc;
      guard <= o_owr ? 2'd2 : guard != 2'd0 ? guard - 2'd1 : guard;
      state <= state_n;
      o_owr <= owr_n;
      o_active <= act_n;
      o_cmd <= cmd_n;
      o_cmd_valid <= cmdv_n;
      o_convert <= conv_n;
      temp <= temp_n;
      sr <= sr_n;
      bitc <= bitc_n;
      byt <= byt_n;
      crc <= crc_n;
      pend <= pend_n;
    end
endmodule

// File: tb/tb_ow_temp_responder.sv
// tb_ow_temp_responder: directed one-wire master bench with a byte scoreboard for ow_temp_responder
`timescale 1ns/1ps
module tb_ow_temp_responder;
  localparam int CPU = 4;
  logic i_clk = 1'b0;
  logic i_rst, m_low, i_owr, o_owr, o_convert, o_cmd_valid, o_active;
  logic [15:0] i_temp;
  logic [7:0] o_cmd;
  int n_vec = 0, n_err = 0, cv_cnt = 0, cnv_cnt = 0, own_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rd, mcrc, ecrc, b8;
  logic [7:0] sp_ref [8];
  logic bt;
  assign i_owr = ~(m_low | o_owr);
  always #5 i_clk = ~i_clk;
  ow_temp_responder #(.CLK_PER_US(CPU)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_owr(i_owr), .o_owr(o_owr), .i_temp(i_temp),
    .o_convert(o_convert), .o_cmd(o_cmd), .o_cmd_valid(o_cmd_valid), .o_active(o_active)
  );
  always @(posedge i_clk) begin
    if (o_cmd_valid) cv_cnt++;
    if (o_convert) cnv_cnt++;
    if (o_owr) own_cnt++;
  end
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic f;
    for (int i = 0; i < 8; i++) begin
      f = c[0] ^ d[i];
      c = (c >> 1) ^ (f ? 8'h8C : 8'h00);
    end
    return c;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_us(input int us);
    repeat (us * CPU) @(posedge i_clk);
    #1;
  endtask
  task automatic wait_owr(input logic v, input int max_cyc, output int n);
    n = 0;
    while (o_owr !== v && n < max_cyc) begin
      @(posedge i_clk);
      #1;
      n++;
    end
  endtask
  task automatic presence();
    int n;
    wait_owr(1'b1, 40 * CPU, n);
    chk("pd_delay_in_range", n >= 30 * CPU && n <= 30 * CPU + 4, 1);
    wait_owr(1'b0, 130 * CPU, n);
    chk("pd_len_in_range", n >= 120 * CPU - 1 && n <= 120 * CPU + 1, 1);
    chk("pd_active", o_active, 1);
    wait_us(5);
  endtask
  task automatic bus_reset();
    m_low = 1'b1;
    wait_us(480);
    m_low = 1'b0;
    presence();
  endtask
  task automatic write_bit(input logic b);
    m_low = 1'b1;
    wait_us(b ? 6 : 40);
    m_low = 1'b0;
    wait_us(b ? 34 : 5);
  endtask
  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask
  task automatic read_bit(output logic b);
    m_low = 1'b1;
    wait_us(2);
    m_low = 1'b0;
    wait_us(11);
    b = i_owr;
    wait_us(22);
  endtask
  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v[i] = b;
    end
  endtask
  task automatic rd_chk(input string tag);
    logic [7:0] e;
    read_byte(last_rd);
    e = exp_q.pop_front();
    chk(tag, last_rd, e);
  endtask
  initial begin
    sp_ref = '{8'h91, 8'h01, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10};
    i_rst = 1'b1;
    m_low = 1'b0;
    i_temp = 16'h0000;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_owr", o_owr, 0);
    chk("rst_convert", o_convert, 0);
    chk("rst_cmd", o_cmd, 8'h00);
    chk("rst_cmd_valid", o_cmd_valid, 0);
    chk("rst_active", o_active, 0);
    i_rst = 1'b0;
    wait_us(5);
    begin : short_pulse
      int n;
      m_low = 1'b1;
      wait_us(200);
      m_low = 1'b0;
      wait_owr(1'b1, 200 * CPU, n);
      chk("short_no_presence", n, 200 * CPU);
      chk("short_active", o_active, 0);
    end
    bus_reset();
    write_byte(8'hCC);
    write_byte(8'hBE);
    chk("dflt_cmd", o_cmd, 8'hBE);
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h05);
    rd_chk("dflt_temp_lsb");
    rd_chk("dflt_temp_msb");
    bus_reset();
    write_byte(8'h55);
    chk("rom55_active", o_active, 0);
    own_cnt = 0;
    exp_q.push_back(8'hFF);
    rd_chk("rom55_released");
    chk("rom55_no_drive", own_cnt, 0);
    i_temp = 16'h0191;
    bus_reset();
    cv_cnt = 0;
    cnv_cnt = 0;
    write_byte(8'hCC);
    write_byte(8'h44);
    i_temp = 16'hABCD;
    chk("conv_cmd_valid_cnt", cv_cnt, 1);
    chk("conv_pulse_cycles", cnv_cnt, 1);
    chk("conv_cmd", o_cmd, 8'h44);
    exp_q.push_back(8'hFF);
    rd_chk("conv_done_ones");
    bus_reset();
    write_byte(8'hCC);
    write_byte(8'hBE);
    ecrc = 8'h00;
    foreach (sp_ref[i]) begin
      exp_q.push_back(sp_ref[i]);
      ecrc = crc8(ecrc, sp_ref[i]);
    end
    exp_q.push_back(ecrc);
    mcrc = 8'h00;
    for (int i = 0; i < 9; i++) begin
      rd_chk($sformatf("sp_byte%0d", i));
      mcrc = crc8(mcrc, last_rd);
    end
    chk("sp_crc_residue", mcrc, 8'h00);
    exp_q.push_back(8'hFF);
    rd_chk("sp_tail_ones");
    bus_reset();
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(b8);
    read_byte(b8);
    read_bit(bt);
    chk("abort_b2_bit0", bt, 1);
    read_bit(bt);
    chk("abort_b2_bit1", bt, 1);
    m_low = 1'b1;
    wait_us(10);
    chk("abort_hold_zero", o_owr, 1);
    wait_us(30);
    chk("abort_released", o_owr, 0);
    wait_us(440);
    m_low = 1'b0;
    presence();
    begin : rst_mid_pd
      int n;
      m_low = 1'b1;
      wait_us(480);
      m_low = 1'b0;
      wait_owr(1'b1, 40 * CPU, n);
      wait_us(50);
      chk("midpd_driving", o_owr, 1);
      i_rst = 1'b1;
      #1;
      chk("midpd_rst_owr", o_owr, 0);
      chk("midpd_rst_cmd", o_cmd, 8'h00);
      chk("midpd_rst_active", o_active, 0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      wait_us(5);
    end
    bus_reset();
    write_byte(8'hCC);
    write_byte(8'hBE);
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h05);
    rd_chk("post_rst_temp_lsb");
    rd_chk("post_rst_temp_msb");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
